// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage.
// Holds the fetch PC and presents the fetched instruction to the IF/ID register.
// Instr_F, BD_F and Exc_Code_F are combinational, so they appear in the same cycle as PC_F.
//
// Optional feature: define IF_ADDR_EXC_EN to enable the AdEL check on the fetch PC.
// The check covers alignment and the 0x3000..0x6FFC fetch window.
// When the macro is undefined, Exc_Code_F is constant 0.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   synchronous, active-high reset (PC <- 0x0000_3000)
//   Req          in   exception/interrupt request; PC <- 0x0000_4180, ignores stall
//   PC_en        in   fetch advance enable (0 = PC holds)
//   Redirect_D   in   branch/jump taken in D stage
//   Target_D     in   redirect target [31:0]
//   Eret_D       in   eret in D stage (beats Redirect_D)
//   EPC          in   eret return address [31:0]
//   Is_BJ_D      in   D-stage instruction is a branch/jump
//   i_inst_rdata in   instruction word for i_inst_addr [31:0]
//   i_inst_addr  out  instruction memory address (= PC_F) [31:0]
//   PC_F         out  fetch PC [31:0]
//   Instr_F      out  fetched instruction, nop when faulting or after eret [31:0]
//   BD_F         out  delay-slot flag
//   Exc_Code_F   out  fetch exception code [4:0] (0 none, 4 AdEL)
module if_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        PC_en,
  input  logic        Redirect_D,
  input  logic [31:0] Target_D,
  input  logic        Eret_D,
  input  logic [31:0] EPC,
  input  logic        Is_BJ_D,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_F,
  output logic        BD_F,
  output logic [4:0]  Exc_Code_F
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned EXC_W  = 5;

  localparam logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [ADDR_W-1:0] PC_STEP    = 32'h0000_0004;
  localparam logic [EXC_W-1:0]  EXC_NONE   = 5'd0;
  localparam logic [EXC_W-1:0]  EXC_ADEL   = 5'd4;

  // Initialised so simulation starts at the reset vector even before the first reset.
  logic [ADDR_W-1:0] pc = RESET_PC;
  logic              addr_fault;

  // PC update: reset > Req > stall > eret > redirect > sequential.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (Req) begin
      pc <= HANDLER_PC;
    end else if (PC_en) begin
      if (Eret_D) begin
        pc <= EPC;
      end else if (Redirect_D) begin
        pc <= Target_D;
      end else begin
        pc <= ADDR_W'(pc + PC_STEP);
      end
    end
  end

`ifdef IF_ADDR_EXC_EN
  localparam logic [ADDR_W-1:0] FETCH_LO = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] FETCH_HI = 32'h0000_6FFC;

  // Misaligned or outside the fetch window.
  assign addr_fault = (pc[1:0] != 2'b00) || (pc < FETCH_LO) || (pc > FETCH_HI);
`else
  assign addr_fault = 1'b0;
`endif

  assign i_inst_addr = pc;
  assign PC_F        = pc;

  // The slot after eret is discarded, so it never excepts and is never a delay slot.
  assign Exc_Code_F  = (addr_fault && !Eret_D) ? EXC_ADEL : EXC_NONE;
  assign Instr_F     = (addr_fault || Eret_D) ? 32'h0000_0000 : i_inst_rdata;
  assign BD_F        = Is_BJ_D && !Eret_D;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized plus directed bench for if_fetch_unit.
// Checks against a reference model of the fetch rules.
// It honours IF_ADDR_EXC_EN the same way the design does.
module tb_if_fetch_unit;

`ifdef IF_ADDR_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Req = 1'b0;
  logic        PC_en = 1'b0;
  logic        Redirect_D = 1'b0;
  logic [31:0] Target_D = '0;
  logic        Eret_D = 1'b0;
  logic [31:0] EPC = '0;
  logic        Is_BJ_D = 1'b0;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] PC_F;
  logic [31:0] Instr_F;
  logic        BD_F;
  logic [4:0]  Exc_Code_F;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_pc = 32'h0000_3000;

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .Req          (Req),
    .PC_en        (PC_en),
    .Redirect_D   (Redirect_D),
    .Target_D     (Target_D),
    .Eret_D       (Eret_D),
    .EPC          (EPC),
    .Is_BJ_D      (Is_BJ_D),
    .i_inst_rdata (i_inst_rdata),
    .i_inst_addr  (i_inst_addr),
    .PC_F         (PC_F),
    .Instr_F      (Instr_F),
    .BD_F         (BD_F),
    .Exc_Code_F   (Exc_Code_F)
  );

  always #5 clk = ~clk;

  // Instruction memory: a distinct, mostly non-zero word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h5A3C};
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check same-cycle outputs, then advance the model.
  task automatic cycle(input bit rst, input bit req, input bit en, input bit redir,
                       input logic [31:0] tgt, input bit eret, input logic [31:0] epc,
                       input bit bj);
    bit          legal;
    logic [31:0] e_exc;
    logic [31:0] e_instr;
    reset = rst; Req = req; PC_en = en; Redirect_D = redir; Target_D = tgt;
    Eret_D = eret; EPC = epc; Is_BJ_D = bj;
    @(negedge clk);
    legal   = (m_pc >= 32'h3000) && (m_pc <= 32'h6FFC) && (m_pc % 4 == 0);
    e_exc   = (EXC_ON && !legal && !eret) ? 32'd4 : 32'd0;
    e_instr = (eret || e_exc != 0) ? 32'd0 : mem_word(m_pc);
    check("pc_f",   PC_F, m_pc);
    check("i_addr", i_inst_addr, m_pc);
    check("instr",  Instr_F, e_instr);
    check("bd",     32'(BD_F), 32'(bj && !eret));
    check("exc",    32'(Exc_Code_F), e_exc);
    @(posedge clk);
    if (rst)       m_pc = 32'h0000_3000;
    else if (req)  m_pc = 32'h0000_4180;
    else if (en) begin
      if (eret)       m_pc = epc;
      else if (redir) m_pc = tgt;
      else            m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    a = 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
    case ($urandom_range(0, 3))
      0, 1:    return a;
      2:       return a + 32'($urandom_range(1, 3));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    // Reset, then straight-line fetch.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc",  PC_F, 32'h3000);
    check("rst_exc", 32'(Exc_Code_F), 32'd0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0); check("seq1", PC_F, 32'h3004);
    cycle(0, 0, 1, 0, 0, 0, 0, 0); check("seq2", PC_F, 32'h3008);
    cycle(0, 0, 1, 0, 0, 0, 0, 0); check("seq3", PC_F, 32'h300C);
    cycle(0, 0, 1, 0, 0, 0, 0, 0); check("seq4", PC_F, 32'h3010);

    // Branch with delay slot: stalled first, then taken.
    cycle(0, 0, 0, 1, 32'h3100, 0, 0, 1); check("stall_hold", PC_F, 32'h3010);
    cycle(0, 0, 1, 1, 32'h3100, 0, 0, 1); check("redir_tgt", PC_F, 32'h3100);

    // Misaligned and out-of-window redirects.
    cycle(0, 0, 1, 1, 32'h3002, 0, 0, 0);
    check("mis_addr",  i_inst_addr, 32'h3002);
    check("mis_exc",   32'(Exc_Code_F), EXC_ON ? 32'd4 : 32'd0);
    check("mis_instr", Instr_F, EXC_ON ? 32'd0 : mem_word(32'h3002));
    cycle(0, 0, 1, 1, 32'h7000, 0, 0, 0);
    check("oor_exc",   32'(Exc_Code_F), EXC_ON ? 32'd4 : 32'd0);

    // Req wins over stall and redirect.
    cycle(0, 1, 0, 1, 32'h3100, 0, 0, 0); check("req_pc", PC_F, 32'h4180);

    // Eret wins over redirect; its slot is squashed by the model checks.
    cycle(0, 0, 1, 1, 32'h3100, 1, 32'h3208, 1); check("eret_pc", PC_F, 32'h3208);

    // Reset wins over Req.
    cycle(1, 1, 1, 0, 0, 0, 0, 0); check("rst_req", PC_F, 32'h3000);

    // PC wraps at the top of the address space.
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0); check("wrap", PC_F, 32'h0000_0000);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pick_addr(),
            $urandom_range(0, 7) == 0, pick_addr(), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: Req  input  1  exception/interrupt request from CP0; forces handler entry.
REQ-004 SHALL have port: PC_en  input  1  fetch advance enable; 0 = stall (PC holds).
REQ-005 SHALL have port: Redirect_D  input  1  branch taken / jump in D stage.
REQ-006 SHALL have port: Target_D  input  32  redirect target address.
REQ-007 SHALL have port: Eret_D  input  1  eret instruction in D stage.
REQ-008 SHALL have port: EPC  input  32  return address from CP0.
REQ-009 SHALL have port: Is_BJ_D  input  1  D-stage instruction is a branch/jump (F instruction is its delay slot).
REQ-010 SHALL have port: i_inst_rdata  input  32  instruction word returned by instruction memory for i_inst_addr (combinational).
REQ-011 SHALL have port: i_inst_addr  output  32  instruction memory address, equal to PC_F.
REQ-012 SHALL have port: PC_F  output  32  PC of the instruction presented to the IF/ID register.
REQ-013 SHALL have port: Instr_F  output  32  instruction presented to the IF/ID register.
REQ-014 SHALL have port: BD_F  output  1  delay-slot flag for Instr_F.
REQ-015 SHALL have port: Exc_Code_F  output  5  fetch exception code (0 = none, 4 = AdEL).

Function
REQ-016 SHALL hold the program counter in a 32-bit register; PC_F and i_inst_addr SHALL equal it.
REQ-017 SHALL update the PC on each rising edge with priority: reset -> 0x0000_3000; else Req -> 0x0000_4180 (regardless of PC_en); else PC_en=0 -> hold; else Eret_D -> EPC; else Redirect_D -> Target_D; else PC+4 (modulo 2^32, wrap 0xFFFF_FFFC -> 0x0000_0000).
REQ-018 SHALL flag AdEL (Exc_Code_F=4) when PC[1:0]!=0 or PC outside 0x0000_3000..0x0000_6FFC inclusive; otherwise Exc_Code_F=0.
REQ-019 SHALL drive Instr_F=0 (nop) whenever Exc_Code_F!=0 or Eret_D=1; otherwise Instr_F=i_inst_rdata.
REQ-020 SHALL drive Exc_Code_F=0 when Eret_D=1 (the instruction after eret is discarded, never excepts).
REQ-021 SHALL drive BD_F=Is_BJ_D, except BD_F=0 when Eret_D=1.
REQ-022 SHALL produce Instr_F, BD_F, Exc_Code_F combinationally in the same cycle as PC_F (zero added latency; one instruction per cycle when PC_en=1).
REQ-023 SHALL keep i_inst_addr at the (possibly faulting) PC; no memory-side suppression.
REQ-024 SHALL, when Req and Eret_D/Redirect_D coincide, take Req; Redirect and Eret are discarded.
REQ-025 SHALL, when Eret_D and Redirect_D coincide, take Eret_D.
REQ-026 SHALL, during stall (PC_en=0), keep all outputs stable provided D-stage inputs are stable.

Reset
REQ-027 SHALL, with reset=1 at a rising edge, set PC to 0x0000_3000 regardless of all other inputs, including Req.
REQ-028 SHALL, in the cycle after reset, present PC_F=0x0000_3000, Exc_Code_F=0, BD_F=Is_BJ_D.
REQ-029 SHALL initialise the PC to 0x0000_3000 at time zero for simulation.

Configuration
REQ-030 SHALL compile address-exception detection under macro IF_ADDR_EXC_EN: defined -> REQ-018 range/alignment check active; undefined -> Exc_Code_F constant 0 and Instr_F=i_inst_rdata except when Eret_D=1.

Verification
REQ-031 SHALL verify: reset 1 cycle then PC_en=1, no redirects, 3 cycles -> PC_F sequence 0x3000, 0x3004, 0x3008, 0x300C.
REQ-032 SHALL verify: PC=0x3010, Redirect_D=1, Target_D=0x3100, Is_BJ_D=1 -> BD_F=1 that cycle, next PC_F=0x3100; with PC_en=0 same inputs -> PC holds 0x3010.
REQ-033 SHALL verify: Redirect to 0x3002 -> next cycle Exc_Code_F=4, Instr_F=0, i_inst_addr=0x3002; redirect to 0x7000 -> Exc_Code_F=4 (macro defined), 0 (macro undefined).
REQ-034 SHALL verify: Req=1 with PC_en=0 and Redirect_D=1 -> next PC_F=0x4180.
REQ-035 SHALL verify: Eret_D=1, EPC=0x3208, Redirect_D=1 -> same cycle Instr_F=0, BD_F=0, Exc_Code_F=0; next PC_F=0x3208.
REQ-036 SHALL verify: reset=1 and Req=1 same edge -> PC_F=0x3000.
